// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared state type, default word width and counter-width helper
package serial_feeder_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_bit_cnt.sv
// serial_bit_cnt: mod-WIDTH bit counter with clear/enable and last-bit flag
// ports: clk, rst_ (async active-low), clr, en, cnt (current bit index), last (cnt == WIDTH-1)
module serial_bit_cnt
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         clr,
  input  logic                         en,
  output logic [cnt_width(WIDTH)-1:0]  cnt,
  output logic                         last
);
  localparam int CW = cnt_width(WIDTH);
  logic [CW-1:0] cnt_q, cnt_d;
  assign last = cnt_q == CW'(WIDTH - 1);
  assign cnt  = cnt_q;
  always_comb cnt_d = clr ? '0 : (en ? (last ? '0 : cnt_q + 1'b1) : cnt_q);
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: valid/ready word loader that streams WIDTH-bit words LSB first, one bit per clock
// ports: clk, rst_ (async active-low), load_valid/load_data/load_ready (word load port),
//        dout/dout_valid/sof (serial stream, sof marks bit 0), busy (shifting)
// SERIAL_FEEDER_LOOP_EN: when defined, the last word repeats until a new one is loaded
module serial_bit_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, hold_q, hold_d;
  logic             hold_full_q, hold_full_d, load_ready_q;
  logic [CW-1:0]    cnt;
  logic             last, accept;
`ifdef SERIAL_FEEDER_LOOP_EN
  logic [WIDTH-1:0] cur_q, cur_d;
`endif
  serial_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst_ (rst_),
    .clr  (!busy),
    .en   (busy),
    .cnt  (cnt),
    .last (last)
  );
  assign busy       = state_q == SHIFT;
  assign dout_valid = busy;
  assign dout       = busy & sreg_q[0];
  assign sof        = busy && cnt == '0;
  assign load_ready = load_ready_q;
  assign accept     = load_valid && load_ready_q;
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`ifdef SERIAL_FEEDER_LOOP_EN
    cur_d       = cur_q;
`endif
    if (state_q == IDLE) begin
      if (accept) begin
        sreg_d  = load_data;
`ifdef SERIAL_FEEDER_LOOP_EN
        cur_d   = load_data;
`endif
        state_d = SHIFT;
      end
    end else if (last) begin
      // word boundary: held word first, then a word arriving on this very edge
      if (hold_full_q) begin
        sreg_d      = hold_q;
`ifdef SERIAL_FEEDER_LOOP_EN
        cur_d       = hold_q;
`endif
        hold_full_d = 1'b0;
      end else if (accept) begin
        sreg_d = load_data;
`ifdef SERIAL_FEEDER_LOOP_EN
        cur_d  = load_data;
`endif
      end else begin
`ifdef SERIAL_FEEDER_LOOP_EN
        sreg_d  = cur_q;
`else
        sreg_d  = '0;
        state_d = IDLE;
`endif
      end
    end else begin
      sreg_d = sreg_q >> 1;
      if (accept) begin
        hold_d      = load_data;
        hold_full_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      load_ready_q <= 1'b1;
`ifdef SERIAL_FEEDER_LOOP_EN
      cur_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      load_ready_q <= !hold_full_d;
`ifdef SERIAL_FEEDER_LOOP_EN
      cur_q        <= cur_d;
`endif
    end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed stimulus against a word-queue model of the serial feeder
module tb_serial_bit_feeder;
  localparam int W = 8;
  logic         clk = 1'b0, rst_ = 1'b0, load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready, dout, dout_valid, sof, busy;
  int           checks = 0, errors = 0;
  logic [W-1:0] q[$];
  int           pos = 0;
  bit           acc;

  serial_bit_feeder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sof        (sof),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: queue holds the word on the wire followed by at most one waiting word
  always @(posedge clk or negedge rst_)
    if (!rst_) begin
      q.delete();
      pos = 0;
    end else begin
      acc = load_valid && (q.size() < 2);
      if (q.size() > 0) begin
        pos++;
        if (pos == W) begin
          pos = 0;
`ifdef SERIAL_FEEDER_LOOP_EN
          if (q.size() > 1 || acc) void'(q.pop_front());
`else
          void'(q.pop_front());
`endif
        end
      end
      if (acc) q.push_back(load_data);
    end

  always @(negedge clk)
    if (rst_) begin
      chk("cmp_valid", {31'd0, dout_valid}, {31'd0, q.size() > 0});
      chk("cmp_dout", {31'd0, dout}, (q.size() > 0) ? {31'd0, q[0][pos]} : 32'd0);
      chk("cmp_sof", {31'd0, sof}, {31'd0, q.size() > 0 && pos == 0});
      chk("cmp_busy", {31'd0, busy}, {31'd0, q.size() > 0});
      chk("cmp_ready", {31'd0, load_ready}, {31'd0, q.size() < 2});
    end

  task automatic drv(input logic v, input logic [W-1:0] d);
    load_valid = v;
    load_data  = d;
  endtask

  task automatic expect_seq(input string nm, input logic [31:0] bits, input logic [31:0] sofs, input int n);
    for (int i = 0; i < n; i++) begin
      chk({nm, "_dout"}, {31'd0, dout}, {31'd0, bits[i]});
      chk({nm, "_valid"}, {31'd0, dout_valid}, 32'd1);
      chk({nm, "_sof"}, {31'd0, sof}, {31'd0, sofs[i]});
      chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, {31'd0, dout_valid}, 32'd0);
    chk({nm, "_dout"}, {31'd0, dout}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_sof", {31'd0, sof}, 32'd0);
    chk("reset_ready", {31'd0, load_ready}, 32'd1);
    rst_ = 1'b1;
    @(negedge clk);
`ifdef SERIAL_FEEDER_LOOP_EN
    drv(1'b1, 8'h91);
    @(negedge clk) drv(1'b0, '0);
    expect_seq("loop", 32'h00919191, 32'h00010101, 24);
`else
    drv(1'b1, 8'h91);
    @(negedge clk) drv(1'b0, '0);
    expect_seq("single", 32'h91, 32'h1, 8);
    chk_idle("single_end");
    @(negedge clk) drv(1'b1, 8'h91);
    @(negedge clk) drv(1'b1, 8'h94);
    fork
      begin @(negedge clk); drv(1'b0, '0); end
      expect_seq("b2b", 32'h9491, 32'h0101, 16);
    join
    chk_idle("b2b_end");
    @(negedge clk) drv(1'b1, 8'h91);
    @(negedge clk) drv(1'b1, 8'h94);
    fork
      begin
        @(negedge clk);
        chk("bp_ready", {31'd0, load_ready}, 32'd0);
        drv(1'b1, 8'hFF);
        repeat (8) @(negedge clk);
        drv(1'b0, '0);
      end
      expect_seq("bp", 32'h00FF9491, 32'h00010101, 24);
    join
    chk_idle("bp_end");
    @(negedge clk) drv(1'b1, 8'h91);
    @(negedge clk) drv(1'b0, '0);
    fork
      begin repeat (7) @(negedge clk); drv(1'b1, 8'h55); @(negedge clk); drv(1'b0, '0); end
      expect_seq("bypass", 32'h5591, 32'h0101, 16);
    join
    chk_idle("bypass_end");
    @(negedge clk) drv(1'b1, 8'h91);
    @(negedge clk) drv(1'b0, '0);
    repeat (3) @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    chk_idle("rst_mid");
    chk("rst_mid_sof", {31'd0, sof}, 32'd0);
    chk("rst_mid_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk) rst_ = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk_idle("post_rst");
    end
    drv(1'b1, 8'h3C);
    @(negedge clk) drv(1'b0, '0);
    expect_seq("after_rst", 32'h3C, 32'h1, 8);
    chk_idle("after_rst_end");
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-in, serial-out feeder that turns WIDTH-bit words into the one-bit-per-clock stream consumed by the sequence detector `check_sm` on its `din` input. Words arrive on a valid/ready load port. Each word is shifted out LSB first. A one-word holding register allows back-to-back words to stream with no idle bit between them. The block sits directly upstream of `check_sm` and replaces the hand-driven rotate register used in bench stimulus.

## Interface
- WIDTH, 8, word length in bits (≥2)
- clk  in  1  rising-edge clock
- rst_  in  1  asynchronous, active-low reset
- load_valid  in  1  load_data is valid this cycle
- load_data  in  WIDTH  word to serialize, bit 0 sent first
- load_ready  out  1  feeder can accept a word this cycle
- dout  out  1  serial bit, drives check_sm din
- dout_valid  out  1  dout carries a real data bit
- sof  out  1  high while dout carries bit 0 of a word
- busy  out  1  state is SHIFT

## Operation
- Accept: a word is accepted on a clock edge where load_valid && load_ready.
- State IDLE:
  - An accepted word loads the shift register sreg and the copy register cur directly.
  - cnt is set to 0 and the next state is SHIFT.
- State SHIFT:
  - Every edge, sreg shifts right by 1 and cnt increments.
  - An accepted word goes to the holding register hold, and hold_full is set.
- Last-bit edge, in SHIFT with cnt == WIDTH-1, in priority order:
  - If hold_full: hold moves to sreg and cur, cnt goes to 0, hold_full clears, and the state stays SHIFT. This is the gapless case.
  - Else, if a word is accepted on this edge: that word bypasses hold into sreg and cur, cnt goes to 0, and the state stays SHIFT.
  - Else: the state goes to IDLE, dout_valid goes to 0, and dout goes to 0.
- load_ready = !hold_full. It is registered, so it is never combinationally dependent on load_valid.
- dout = sreg[0] while dout_valid is 1; otherwise dout = 0.
- sof = dout_valid && cnt == 0.
- cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1; at WIDTH-1 it wraps to 0.
- Reset mid-word: the word in sreg and any held word are discarded. There is no partial-word output after reset is released.

## Timing
- Reset values: dout 0, dout_valid 0, sof 0, load_ready 1, busy 0, state IDLE, sreg/cur/hold 0, hold_full 0, cnt 0.
- Reset asserts asynchronously. Deassertion is expected synchronous to clk.
- Latency: a word accepted on edge N in IDLE presents bit 0 on dout after edge N and holds it until edge N+1. Bit k is presented after edge N+k.
- A word occupies dout for exactly WIDTH cycles.
- Gapless streaming: if the next word is accepted at least one edge before the last-bit edge, or on it, bit 0 of that word follows bit WIDTH-1 of the current word on the very next cycle.
- All outputs are registered, or are simple decodes of registered state (sof, busy). None of them depends combinationally on load_valid or load_data.

## Configuration
- Macro: SERIAL_FEEDER_LOOP_EN.
- Defined:
  - At a last-bit edge with no held word and no accept, sreg reloads from cur and the state stays SHIFT.
  - The current word therefore repeats indefinitely, and sof pulses every WIDTH cycles.
  - A newly accepted word replaces the repeating word at the next word boundary.
  - Once the block leaves IDLE, it returns to IDLE only on reset.
- Undefined: the block returns to IDLE after the last word, as described in Operation. cur is unused and may be optimized away.

## Structure
- Package serial_feeder_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - the default WIDTH constant;
  - the function that computes the counter width.
- Sub-module: serial_bit_cnt, a mod-WIDTH counter with clear/enable inputs and a last-bit flag output.
- The shift, hold and FSM logic live in the top module.

## Test plan
- Single word: load 8'b1001_0001 in IDLE -> dout over the next 8 cycles = 1,0,0,0,1,0,0,1. sof is high only on the first of those cycles. dout_valid drops to 0 on cycle 9.
- Back-to-back: load 0x91, then 0x94 while the first is shifting -> 16 contiguous valid bits: 1,0,0,0,1,0,0,1,0,0,1,0,1,0,0,1. sof pulses at bits 0 and 8. No gap.
- Backpressure: load 0x91, 0x94 and 0xFF with load_valid held high -> load_ready is 0 after 0x94 fills hold. 0xFF is accepted on the first edge of 0x94 and streams immediately after it.
- Bypass on last edge: present 0x55 exactly on the last-bit edge of 0x91 with hold empty -> 0x55 bit 0 appears on the next cycle, and busy stays 1.
- Reset mid-word: assert rst_ = 0 after 3 bits of 0x91 -> all outputs go to their reset values immediately. After release, dout stays 0 and dout_valid stays 0 until a new load.
- Loop mode (SERIAL_FEEDER_LOOP_EN): load 0x91 once -> the pattern 1,0,0,0,1,0,0,1 repeats for at least 3 words with sof every 8 cycles. When fed to check_sm, find_out pulses at the expected positions.
